// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the forwarding/hazard logic.
//   FWD_* : operand-mux select codes at the EX stage inputs
//   slot_t: per-stage tracking record {valid, rd, reg_write, is_load}
//   slot_writes(): true when a slot will write a given (non-x0) register
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;  // ID/EX register-file data
  localparam logic [1:0] FWD_MEM = 2'd1;  // EX/MEM ALU result
  localparam logic [1:0] FWD_WB  = 2'd2;  // MEM/WB writeback value
  localparam logic [1:0] FWD_RET = 2'd3;  // writeback-hold (retired last cycle)

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } slot_t;

  function automatic logic slot_writes(input slot_t s, input logic [REG_AW_DEF-1:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Combinational priority matcher for one source operand.
//   rs, use_rs         : source register and its use flag (already qualified by id_valid)
//   ex/mem/wb_slot     : in-flight instruction records, youngest first
//   sel                : forwarding select for the operand mux
//   load_hit           : the EX-stage instruction is a load producing this operand
module fwd_match
  import pipe_pkg::*;
(
  input  logic [REG_AW_DEF-1:0] rs,
  input  logic                  use_rs,
  input  slot_t                 ex_slot,
  input  slot_t                 mem_slot,
  input  slot_t                 wb_slot,
  output logic [1:0]            sel,
  output logic                  load_hit
);

  logic unused_is_load;
  assign unused_is_load = mem_slot.is_load ^ wb_slot.is_load;

  // Slots are one stage older by the time this operand reaches EX, so the
  // EX producer is read from EX/MEM, the MEM producer from MEM/WB, and so on.
  always_comb begin
    sel      = FWD_RF;
    load_hit = 1'b0;
    if (use_rs) begin
      if (slot_writes(ex_slot, rs)) begin
        sel      = FWD_MEM;
        load_hit = ex_slot.is_load;
      end else if (slot_writes(mem_slot, rs)) begin
        sel = FWD_WB;
      end else if (slot_writes(wb_slot, rs)) begin
        sel = FWD_RET;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
//   clk, rst_n              : core clock, async active-low reset
//   id_*                    : decoded fields of the instruction in ID
//   stall_ext               : memory-side stall, freezes all state
//   flush                   : taken branch/jump, kills the instruction leaving ID
//   fwd_sel_a / fwd_sel_b   : registered operand-mux selects, valid in EX
//   ld_stall                : combinational load-use stall (hold PC, IF/ID)
module hazard_fwd_unit #(
  parameter int REG_AW = pipe_pkg::REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              stall_ext,
  input  logic              flush,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              ld_stall
);
  import pipe_pkg::*;

  slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [1:0] match_a, match_b;
  logic       hit_a, hit_b;

  fwd_match u_match_a (
    .rs       (id_rs1),
    .use_rs   (id_use_rs1 && id_valid),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (match_a),
    .load_hit (hit_a)
  );

  fwd_match u_match_b (
    .rs       (id_rs2),
    .use_rs   (id_use_rs2 && id_valid),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (match_b),
    .load_hit (hit_b)
  );

  // A flush already replaces the ID instruction with a bubble, so no stall is
  // needed; a frozen pipeline cannot take a stall either.
  assign ld_stall = (hit_a || hit_b) && !flush && !stall_ext;

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (!stall_ext) begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (flush || ld_stall) begin
        ex_d    = '0;
        sel_a_d = FWD_RF;
        sel_b_d = FWD_RF;
      end else begin
        ex_d.valid     = id_valid;
        ex_d.rd        = id_rd;
        ex_d.reg_write = id_reg_write;
        ex_d.is_load   = id_is_load;
        sel_a_d        = match_a;
        sel_b_d        = match_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign fwd_sel_a = sel_a_q;
  assign fwd_sel_b = sel_b_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_ext, flush;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic       ld_stall;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_AW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .stall_ext    (stall_ext),
    .flush        (flush),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .ld_stall     (ld_stall)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drives one ID-stage cycle (entered just after a falling edge), checks the
  // combinational stall, queues the selects expected in the following EX
  // cycle and compares them once the rising edge has registered them.
  task automatic step(input string tag,
                      input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic we, input logic ld, input logic se, input logic fl,
                      input logic exp_stall, input logic [1:0] ea, input logic [1:0] eb);
    logic [3:0] e;
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = we; id_is_load = ld; stall_ext = se; flush = fl;
    #1;
    chk({tag, ".stall"}, {1'b0, ld_stall}, {1'b0, exp_stall});
    exp_q.push_back({ea, eb});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s.queue: observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".sel_a"}, fwd_sel_a, e[3:2]);
      chk({tag, ".sel_b"}, fwd_sel_b, e[1:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_is_load = 0; stall_ext = 0; flush = 0;
    @(negedge clk); @(negedge clk);
    chk("rst.sel_a", fwd_sel_a, 2'd0);
    chk("rst.sel_b", fwd_sel_b, 2'd0);
    chk("rst.stall", {1'b0, ld_stall}, 2'd0);
    rst_n = 1'b1;

    //    tag         v  rs1 u1 rs2 u2 rd we ld se fl  stall a  b
    step("add_x5",    1,  1, 1,  2, 1,  5, 1, 0, 0, 0,  0,   0, 0);
    step("ex_fwd",    1,  5, 1,  7, 1,  6, 1, 0, 0, 0,  0,   1, 0);
    step("prod10",    1,  1, 1,  2, 1, 10, 1, 0, 0, 0,  0,   0, 0);
    step("ind11",     1,  3, 1,  4, 1, 11, 1, 0, 0, 0,  0,   0, 0);
    step("dist1",     1, 10, 1, 10, 1, 15, 1, 0, 0, 0,  0,   2, 2);
    step("prod12",    1,  1, 1,  2, 1, 12, 1, 0, 0, 0,  0,   0, 0);
    step("ind13",     1,  1, 1,  2, 1, 13, 1, 0, 0, 0,  0,   0, 0);
    step("ind14",     1,  1, 1,  2, 1, 14, 1, 0, 0, 0,  0,   0, 0);
    step("dist2",     1, 12, 1, 13, 1, 31, 1, 0, 0, 0,  0,   3, 2);
    step("prod16",    1,  1, 1,  2, 1, 16, 1, 0, 0, 0,  0,   0, 0);
    step("ind17",     1,  1, 1,  2, 1, 17, 1, 0, 0, 0,  0,   0, 0);
    step("ind18",     1,  1, 1,  2, 1, 18, 1, 0, 0, 0,  0,   0, 0);
    step("ind19",     1,  1, 1,  2, 1, 19, 1, 0, 0, 0,  0,   0, 0);
    step("dist3",     1, 16, 1,  0, 1, 21, 1, 0, 0, 0,  0,   0, 0);
    step("w20a",      1,  1, 1,  2, 1, 20, 1, 0, 0, 0,  0,   0, 0);
    step("w20b",      1,  1, 1,  2, 1, 20, 1, 0, 0, 0,  0,   0, 0);
    step("youngest",  1, 20, 1, 21, 1, 22, 1, 0, 0, 0,  0,   1, 3);
    step("lw_x8",     1,  2, 1,  0, 0,  8, 1, 1, 0, 0,  0,   0, 0);
    step("lu_stall",  1,  8, 1,  8, 1,  9, 1, 0, 0, 0,  1,   0, 0);
    step("lu_retry",  1,  8, 1,  8, 1,  9, 1, 0, 0, 0,  0,   2, 2);
    step("after_lu",  1,  9, 1,  8, 1, 24, 1, 0, 0, 0,  0,   1, 3);
    step("lw_x0",     1,  1, 1,  0, 0,  0, 1, 1, 0, 0,  0,   0, 0);
    step("use_x0",    1,  0, 1,  0, 1,  7, 1, 0, 0, 0,  0,   0, 0);
    step("lw_x23",    1,  1, 1,  0, 0, 23, 1, 1, 0, 0,  0,   0, 0);
    step("unused_rs2",1, 24, 1, 23, 0, 26, 1, 0, 0, 0,  0,   0, 0);
    step("lw_x25",    1, 23, 1,  0, 0, 25, 1, 1, 0, 0,  0,   2, 0);
    step("sext1",     1, 25, 1, 26, 1, 30, 1, 0, 1, 0,  0,   2, 0);
    step("sext2",     1, 25, 1, 26, 1, 30, 1, 0, 1, 0,  0,   2, 0);
    step("sext3_fl",  1, 25, 1, 26, 1, 30, 1, 0, 1, 1,  0,   2, 0);
    step("sext_lu",   1, 25, 1, 26, 1, 30, 1, 0, 0, 0,  1,   0, 0);
    step("sext_retry",1, 25, 1, 26, 1, 30, 1, 0, 0, 0,  0,   2, 3);
    step("lw_x27",    1,  0, 0,  0, 0, 27, 1, 1, 0, 0,  0,   0, 0);
    step("flush_lu",  1, 27, 1,  1, 1, 28, 1, 0, 0, 1,  0,   0, 0);
    step("post_flush",1, 27, 1, 28, 1, 11, 1, 0, 0, 0,  0,   2, 0);
    step("lw_x29",    1, 11, 1,  0, 0, 29, 1, 1, 0, 0,  0,   1, 0);

    // Asynchronous reset while a load-use pair is pending.
    id_valid = 1; id_rs1 = 29; id_use_rs1 = 1; id_rs2 = 29; id_use_rs2 = 1;
    id_rd = 9; id_reg_write = 1; id_is_load = 0; stall_ext = 0; flush = 0;
    #1;
    chk("pre_rst.stall", {1'b0, ld_stall}, 2'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.stall", {1'b0, ld_stall}, 2'd0);
    chk("mid_rst.sel_a", fwd_sel_a, 2'd0);
    chk("mid_rst.sel_b", fwd_sel_b, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst",  1, 29, 1, 29, 1,  9, 1, 0, 0, 0,  0,   0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
